spu_controller: RTL and testbench
=================================

SPU_CONTROLLER -- requirements
Module: spu_controller

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter and instruction-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports start  input  1  (leave INIT) and halted  output  1  (high in HALT).
REQ-005 SHALL have ports im_addr  output  PC_W  (instruction address), im_rd  output  1  (instruction read strobe) and im_data  input  16  (instruction word, combinational read, valid in the same cycle as im_rd).
REQ-006 SHALL have ports d_addr  output  8,  d_rd  output  1  and  d_wr  output  1  (data-memory address, read strobe and write strobe).
REQ-007 SHALL have ports rf_w_addr  output  4,  rf_w_wr  output  1,  rf_rp_addr  output  4,  rf_rp_rd  output  1,  rf_rq_addr  output  4  and  rf_rq_rd  output  1  (register-file write and read controls).
REQ-008 SHALL have ports alu_s1, alu_s0, rf_s1, rf_s0  output  1 each  (ALU and write-mux selects), loac  output  8  (constant) and pco_en  input  1  (selected p-port register equals zero).

Function
REQ-009 SHALL implement states INIT, FETCH, DECODE, LOAD, STORE, ADD, LOADC, SUB, JUMPZ and HALT, with a PC_W-bit PC and a 16-bit IR.
REQ-010 SHALL stay in INIT until start=1, forcing PC=0, then go to FETCH.
REQ-011 FETCH SHALL assert im_rd with im_addr=PC, load IR<=im_data and PC<=PC+1 (mod 2^PC_W), then go to DECODE.
REQ-012 DECODE SHALL dispatch on IR[15:12]: 0000 LOAD, 0001 STORE, 0010 ADD, 0011 LOADC, 0100 SUB, 0101 JUMPZ, 1111 HALT, any other opcode back to FETCH (NOP).
REQ-013 Field names: ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], d=IR[7:0].
REQ-014 LOAD SHALL drive d_addr=d, d_rd=1, rf_s1=0, rf_s0=1, rf_w_addr=ra, rf_w_wr=1.
REQ-015 STORE SHALL drive d_addr=d, d_wr=1, rf_rp_addr=ra, rf_rp_rd=1.
REQ-016 ADD SHALL drive rf_rp_addr=rb, rf_rq_addr=rc, both read enables, {alu_s1,alu_s0}=01, rf_s1=rf_s0=0, rf_w_addr=ra, rf_w_wr=1; SUB SHALL be identical except {alu_s1,alu_s0}=10.
REQ-017 LOADC SHALL drive rf_s1=1, loac=d, rf_w_addr=ra, rf_w_wr=1.
REQ-018 JUMPZ SHALL drive rf_rp_addr=ra, rf_rp_rd=1; if pco_en=1 it SHALL set PC<=PC+sext(d)-1 (target = address of the JUMPZ instruction + signed d, mod 2^PC_W), otherwise leave PC unchanged.
REQ-019 Each execute state SHALL last exactly one cycle and return to FETCH: 3 cycles per instruction, 2 for NOP.
REQ-020 HALT SHALL hold halted=1 and keep all strobes low until reset; start is ignored outside INIT.
REQ-021 Any control output not named for the current state SHALL be 0, and no state SHALL assert d_rd and d_wr together.
REQ-022 Outputs SHALL be decoded from state and IR only, except that the PC update in JUMPZ uses pco_en.

Reset
REQ-023 rst=0 SHALL immediately force state INIT, PC=0 and IR=0; every output SHALL be 0, including mid-instruction.
REQ-024 After rst returns high the block SHALL wait in INIT for start.

Configuration
REQ-025 With SPU_JUMPZ_EN defined, opcode 0101 SHALL execute JUMPZ as in REQ-018.
REQ-026 Without SPU_JUMPZ_EN, opcode 0101 SHALL be a NOP per REQ-012 and the JUMPZ state SHALL not exist.

Verification
REQ-027 Reset, then start=1 with im_data=3105 at PC 0 -> FETCH im_addr=0, then LOADC with rf_w_addr=1, loac=0x05, rf_s1=1, rf_w_wr=1; PC=1.
REQ-028 Instruction 2312 -> ADD cycle: rf_rp_addr=1, rf_rq_addr=2, alu=01, rf_w_addr=3, rf_w_wr=1; instruction 4312 -> same with alu=10.
REQ-029 Instructions 0A10 and 1A20 -> LOAD d_addr=0x10, d_rd=1, rf_s0=1, rf_w_addr=A; STORE d_addr=0x20, d_wr=1, rf_rp_addr=A.
REQ-030 JUMPZ 52FE at address 5 (SPU_JUMPZ_EN): pco_en=1 -> next im_addr=3; pco_en=0 -> next im_addr=6; without the macro -> NOP, next im_addr=6.
REQ-031 F000 -> halted=1, no strobes for 20 cycles, start pulses ignored; rst low during an ADD cycle -> rf_w_wr=0 immediately, state INIT, PC=0.

Source files
------------

// File: rtl/spu_controller.sv
// Sequencing controller for a small single-issue processor: fetch/decode/execute FSM.
// Define SPU_JUMPZ_EN to enable the conditional relative jump (opcode 0101).
module spu_controller #(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            halted,
   output logic [PC_W-1:0] im_addr,
   output logic            im_rd,
   input  logic [15:0]     im_data,
   output logic [7:0]      d_addr,
   output logic            d_rd,
   output logic            d_wr,
   output logic [3:0]      rf_w_addr,
   output logic            rf_w_wr,
   output logic [3:0]      rf_rp_addr,
   output logic            rf_rp_rd,
   output logic [3:0]      rf_rq_addr,
   output logic            rf_rq_rd,
   output logic            alu_s1,
   output logic            alu_s0,
   output logic            rf_s1,
   output logic            rf_s0,
   output logic [7:0]      loac,
   input  logic            pco_en
);

   localparam logic [3:0] S_INIT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_LOAD   = 4'd3;
   localparam logic [3:0] S_STORE  = 4'd4;
   localparam logic [3:0] S_ADD    = 4'd5;
   localparam logic [3:0] S_LOADC  = 4'd6;
   localparam logic [3:0] S_SUB    = 4'd7;
`ifdef SPU_JUMPZ_EN
   localparam logic [3:0] S_JUMPZ  = 4'd8;
`endif
   localparam logic [3:0] S_HALT   = 4'd9;

   localparam logic [PC_W-1:0] PC_ONE = 1;

   logic [3:0]      state, nxt;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;

   logic [3:0] ra, rb, rc;
   logic [7:0] d;
   assign ra = ir[11:8];
   assign rb = ir[7:4];
   assign rc = ir[3:0];
   assign d  = ir[7:0];

   always_comb begin
      nxt = state;
      case (state)
         S_INIT:   nxt = start ? S_FETCH : S_INIT;
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (ir[15:12])
               4'b0000: nxt = S_LOAD;
               4'b0001: nxt = S_STORE;
               4'b0010: nxt = S_ADD;
               4'b0011: nxt = S_LOADC;
               4'b0100: nxt = S_SUB;
`ifdef SPU_JUMPZ_EN
               4'b0101: nxt = S_JUMPZ;
`endif
               4'b1111: nxt = S_HALT;
               default: nxt = S_FETCH;
            endcase
         end
         S_HALT:   nxt = S_HALT;
         S_LOAD, S_STORE, S_ADD, S_LOADC, S_SUB: nxt = S_FETCH;
`ifdef SPU_JUMPZ_EN
         S_JUMPZ:  nxt = S_FETCH;
`endif
         default:  nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_INIT;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= nxt;
         case (state)
            S_INIT: pc <= '0;
            S_FETCH: begin
               ir <= im_data;
               pc <= pc + PC_ONE;
            end
`ifdef SPU_JUMPZ_EN
            // PC already points past the JUMPZ, so back off by one to make d relative to it
            S_JUMPZ: if (pco_en) pc <= pc + {{(PC_W-8){d[7]}}, d} - PC_ONE;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      halted     = 1'b0;
      im_addr    = '0;
      im_rd      = 1'b0;
      d_addr     = '0;
      d_rd       = 1'b0;
      d_wr       = 1'b0;
      rf_w_addr  = '0;
      rf_w_wr    = 1'b0;
      rf_rp_addr = '0;
      rf_rp_rd   = 1'b0;
      rf_rq_addr = '0;
      rf_rq_rd   = 1'b0;
      alu_s1     = 1'b0;
      alu_s0     = 1'b0;
      rf_s1      = 1'b0;
      rf_s0      = 1'b0;
      loac       = '0;
      case (state)
         S_FETCH: begin
            im_addr = pc;
            im_rd   = 1'b1;
         end
         S_LOAD: begin
            d_addr    = d;
            d_rd      = 1'b1;
            rf_s0     = 1'b1;
            rf_w_addr = ra;
            rf_w_wr   = 1'b1;
         end
         S_STORE: begin
            d_addr     = d;
            d_wr       = 1'b1;
            rf_rp_addr = ra;
            rf_rp_rd   = 1'b1;
         end
         S_ADD, S_SUB: begin
            rf_rp_addr = rb;
            rf_rp_rd   = 1'b1;
            rf_rq_addr = rc;
            rf_rq_rd   = 1'b1;
            alu_s1     = (state == S_SUB);
            alu_s0     = (state == S_ADD);
            rf_w_addr  = ra;
            rf_w_wr    = 1'b1;
         end
         S_LOADC: begin
            rf_s1     = 1'b1;
            loac      = d;
            rf_w_addr = ra;
            rf_w_wr   = 1'b1;
         end
`ifdef SPU_JUMPZ_EN
         S_JUMPZ: begin
            rf_rp_addr = ra;
            rf_rp_rd   = 1'b1;
         end
`endif
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spu_controller.sv
// Randomized self-checking bench for spu_controller: an instruction-level model
// predicts the output pattern of every fetch, decode and execute cycle.
module tb_spu_controller;

   logic        clk = 1'b0;
   logic        rst, start, pco_en;
   logic        halted, im_rd, d_rd, d_wr, rf_w_wr, rf_rp_rd, rf_rq_rd;
   logic        alu_s1, alu_s0, rf_s1, rf_s0;
   logic [15:0] im_addr, im_data;
   logic [7:0]  d_addr, loac;
   logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;

   typedef struct packed {
      logic        halted;
      logic        im_rd;
      logic [15:0] im_addr;
      logic [7:0]  d_addr;
      logic        d_rd;
      logic        d_wr;
      logic [3:0]  w_addr;
      logic        w_wr;
      logic [3:0]  rp_addr;
      logic        rp_rd;
      logic [3:0]  rq_addr;
      logic        rq_rd;
      logic        alu_s1;
      logic        alu_s0;
      logic        rf_s1;
      logic        rf_s0;
      logic [7:0]  loac;
   } outs_t;

   outs_t       got;
   logic [15:0] mem [0:255];
   logic [15:0] pc;
   int          n_chk = 0;
   int          n_pass = 0;

   assign got = {halted, im_rd, im_addr, d_addr, d_rd, d_wr, rf_w_addr, rf_w_wr,
                 rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd, alu_s1, alu_s0, rf_s1, rf_s0, loac};
   assign im_data = mem[im_addr[7:0]];

   always #5 clk = ~clk;

   spu_controller #(.PC_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .halted(halted),
      .im_addr(im_addr), .im_rd(im_rd), .im_data(im_data),
      .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
      .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
      .rf_rp_addr(rf_rp_addr), .rf_rp_rd(rf_rp_rd),
      .rf_rq_addr(rf_rq_addr), .rf_rq_rd(rf_rq_rd),
      .alu_s1(alu_s1), .alu_s0(alu_s0), .rf_s1(rf_s1), .rf_s0(rf_s0),
      .loac(loac), .pco_en(pco_en)
   );

   task automatic chk(input string tag, input outs_t obs, input outs_t exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (pc model %h)", tag, obs, exp, pc);
   endtask

`ifdef SPU_JUMPZ_EN
   localparam bit JZ = 1'b1;
`else
   localparam bit JZ = 1'b0;
`endif

   function automatic bit is_exec(input logic [3:0] op);
      return (op <= 4'd4) || (op == 4'd5 && JZ);
   endfunction

   // Expected execute-cycle outputs, straight from the instruction table
   function automatic outs_t exp_exec(input logic [15:0] iw);
      outs_t e = '0;
      case (iw[15:12])
         4'd0: begin e.d_addr = iw[7:0]; e.d_rd = 1; e.rf_s0 = 1; e.w_addr = iw[11:8]; e.w_wr = 1; end
         4'd1: begin e.d_addr = iw[7:0]; e.d_wr = 1; e.rp_addr = iw[11:8]; e.rp_rd = 1; end
         4'd2, 4'd4: begin
            e.rp_addr = iw[7:4]; e.rp_rd = 1; e.rq_addr = iw[3:0]; e.rq_rd = 1;
            e.alu_s1 = (iw[15:12] == 4'd4); e.alu_s0 = (iw[15:12] == 4'd2);
            e.w_addr = iw[11:8]; e.w_wr = 1;
         end
         4'd3: begin e.rf_s1 = 1; e.loac = iw[7:0]; e.w_addr = iw[11:8]; e.w_wr = 1; end
         4'd5: begin e.rp_addr = iw[11:8]; e.rp_rd = 1; end
         default: ;
      endcase
      return e;
   endfunction

   // pz_mode: 0/1 forces pco_en during execute, 2 randomizes it
   task automatic step_instr(input int pz_mode, input bit rst_exec);
      outs_t       e;
      logic [15:0] iw, at;
      logic        pz;
      @(negedge clk);
      start = 1'($urandom); pco_en = 1'($urandom);
      e = '0; e.im_rd = 1; e.im_addr = pc;
      chk("fetch", got, e);
      at = pc; iw = mem[pc[7:0]]; pc = pc + 16'd1;
      @(negedge clk);
      start = 1'($urandom); pco_en = 1'($urandom);
      chk("decode", got, '0);
      if (iw[15:12] == 4'hF || !is_exec(iw[15:12])) return;
      @(negedge clk);
      pz = (pz_mode == 2) ? 1'($urandom) : 1'(pz_mode);
      start = 1'($urandom); pco_en = pz;
      chk("exec", got, exp_exec(iw));
      if (iw[15:12] == 4'd5 && pz) pc = at + {{8{iw[7]}}, iw[7:0]};
      if (rst_exec) begin
         rst = 1'b0;
         #1 chk("rst_mid", got, '0);
      end
   endtask

   task automatic idle_init(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("init", got, '0);
      end
   endtask

   initial begin
      outs_t e;
      rst = 1'b0; start = 1'b0; pco_en = 1'b0;
      for (int i = 0; i < 256; i++)
         mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      mem[0] = 16'h3105; mem[1] = 16'h2312; mem[2] = 16'h4312;
      mem[3] = 16'h0A10; mem[4] = 16'h1A20; mem[5] = 16'h52FE;
      #2 chk("reset", got, '0);
      @(negedge clk); rst = 1'b1;
      idle_init(3);
      start = 1'b1; pc = 16'd0;
      for (int i = 0; i < 5; i++) step_instr(2, 1'b0);
      step_instr(1, 1'b0);
      if (JZ) begin
         step_instr(2, 1'b0); step_instr(2, 1'b0);
         step_instr(0, 1'b0);
      end
      for (int i = 0; i < 150; i++) step_instr(2, 1'b0);

      // HALT: strobes stay low and start is ignored
      mem[pc[7:0]] = 16'hF000;
      step_instr(2, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'($urandom); pco_en = 1'($urandom);
         e = '0; e.halted = 1;
         chk("halt", got, e);
      end

      // Reset during an ADD execute cycle, then restart from PC 0
      rst = 1'b0; start = 1'b0;
      #1 chk("rst_halt", got, '0);
      mem[0] = 16'h2312;
      @(negedge clk); rst = 1'b1;
      idle_init(2);
      start = 1'b1; pc = 16'd0;
      step_instr(2, 1'b1);
      start = 1'b0;
      @(negedge clk); rst = 1'b1;
      idle_init(2);
      start = 1'b1; pc = 16'd0;
      step_instr(2, 1'b0);
      step_instr(2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
